// File: rtl/param_ring_counter.sv
// Parameterised up/down ring counter with a per-run round count.
// A start pulse captures limit, direction and round count; the run ends on the final wrap or on stop.
module param_ring_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             en,
    input  logic             dir,
    input  logic [WIDTH-1:0] i_num_cnt,
    input  logic [RW-1:0]    i_num_round,
    output logic [WIDTH-1:0] cnt_o,
    output logic [RW-1:0]    round_o,
    output logic             wrap_o,
    output logic             done_o,
    output logic             busy_o
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [RW-1:0]    round_q, round_d;
    logic [RW-1:0]    nr_q, nr_d;
    logic             dir_q, dir_d;

    logic             run;
    logic             term;
    logic [RW-1:0]    nr_m1;

    assign run   = (state_q == StRun);
    assign term  = dir_q ? (cnt_q == '0) : (cnt_q == lim_q);
    assign nr_m1 = nr_q - RW'(1);

    // rst gates the pulses so they stay low in a reset cycle even mid-run.
    assign wrap_o  = run & en & ~stop & term & ~rst;
    assign done_o  = wrap_o & (nr_q != '0) & (round_q == nr_m1);
    assign busy_o  = run;
    assign cnt_o   = cnt_q;
    assign round_o = round_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        round_d = round_q;
        nr_d    = nr_q;
        dir_d   = dir_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    lim_d   = i_num_cnt;
                    dir_d   = dir;
                    nr_d    = i_num_round;
                    round_d = '0;
                    cnt_d   = dir ? i_num_cnt : '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (en) begin
                    if (term) begin
                        cnt_d = dir_q ? lim_q : '0;
                        if (done_o) begin
                            round_d = nr_q;
                            state_d = StIdle;
                        end else begin
                            round_d = round_q + RW'(1);
                        end
                    end else begin
                        cnt_d = dir_q ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            lim_q   <= '0;
            round_q <= '0;
            nr_q    <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: tb/tb_param_ring_counter.sv
// Table-driven bench for param_ring_counter: each row is one clock cycle of inputs plus the
// outputs expected in that cycle; expectations flow through a scoreboard queue.
module tb_param_ring_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       en;
    logic       dir;
    logic [7:0] i_num_cnt;
    logic [7:0] i_num_round;
    logic [7:0] cnt_o;
    logic [7:0] round_o;
    logic       wrap_o;
    logic       done_o;
    logic       busy_o;

    param_ring_counter #(
        .WIDTH(8),
        .RW   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .dir        (dir),
        .i_num_cnt  (i_num_cnt),
        .i_num_round(i_num_round),
        .cnt_o      (cnt_o),
        .round_o    (round_o),
        .wrap_o     (wrap_o),
        .done_o     (done_o),
        .busy_o     (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, stop, en, dir;
        logic [7:0] nc, nr;
        logic [7:0] cnt, rnd;
        logic       wrap, done, busy;
    } vec_t;

    typedef struct {
        int         row;
        logic [7:0] cnt, rnd;
        logic       wrap, done, busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   row_no = 0;

    function automatic vec_t mk(input logic r, input logic s, input logic sp, input logic e,
                                input logic d, input logic [7:0] nc, input logic [7:0] nr,
                                input logic [7:0] c, input logic [7:0] rn, input logic w,
                                input logic dn, input logic b);
        vec_t v;
        v.rst = r;  v.start = s; v.stop = sp; v.en = e; v.dir = d;
        v.nc  = nc; v.nr = nr;
        v.cnt = c;  v.rnd = rn;  v.wrap = w;  v.done = dn; v.busy = b;
        return v;
    endfunction

    task automatic check(input string name, input int row, input logic [7:0] act,
                         input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, req);
        end
    endtask

    // One cycle: drive at negedge, queue expectation, compare 1 ns later (well before posedge).
    task automatic run_row(input vec_t v);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst         = v.rst;
        start       = v.start;
        stop        = v.stop;
        en          = v.en;
        dir         = v.dir;
        i_num_cnt   = v.nc;
        i_num_round = v.nr;
        row_no++;
        if (!v.rst) begin
            e.row = row_no; e.cnt = v.cnt; e.rnd = v.rnd;
            e.wrap = v.wrap; e.done = v.done; e.busy = v.busy;
            sb.push_back(e);
        end
        #1;
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check("cnt_o",   got.row, cnt_o,          got.cnt);
            check("round_o", got.row, round_o,        got.rnd);
            check("wrap_o",  got.row, 8'(wrap_o),     8'(got.wrap));
            check("done_o",  got.row, 8'(done_o),     8'(got.done));
            check("busy_o",  got.row, 8'(busy_o),     8'(got.busy));
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; dir = 1'b0;
        i_num_cnt = '0; i_num_round = '0;

        //            rst st sp en d  nc      nr      cnt     rnd     w  dn b
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 0));
        // idle ignores en/stop
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 0));
        // up, one round, limit 3
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'd3,   8'd1,   8'd0,   8'd0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd3,   8'd0,   1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd1,   0, 0, 0));
        // down, two rounds, limit 2
        tbl.push_back(mk(0, 1, 0, 1, 1, 8'd2,   8'd2,   8'd0,   8'd1,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd1,   1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   8'd0,   8'd2,   8'd2,   0, 0, 0));
        // gated enable, limit 5, then stop
        tbl.push_back(mk(0, 1, 0, 0, 0, 8'd5,   8'd1,   8'd2,   8'd2,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   8'd0,   8'd1,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   8'd0,   8'd2,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'd0,   8'd0,   8'd3,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd3,   8'd0,   0, 0, 0));
        // free-running, limit 1; en low on a term cycle; stop on a term cycle
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'd1,   8'd0,   8'd3,   8'd0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   8'd0,   8'd1,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd1,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd2,   0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'd0,   8'd0,   8'd1,   8'd2,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd2,   0, 0, 0));
        // limit 4 free-running; start pulses mid-run carry different settings
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'd4,   8'd0,   8'd1,   8'd2,   0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 8'd1,   8'd1,   8'd0,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 1, 8'd1,   8'd1,   8'd1,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd3,   8'd0,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd4,   8'd0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd1,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd2,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd3,   8'd1,   0, 0, 1));
        // reset at cnt 4 / round 1 with a start in the same cycle
        tbl.push_back(mk(1, 1, 0, 1, 0, 8'd3,   8'd1,   8'd0,   8'd0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 0));
        // limit 0: wrap on every enabled cycle
        tbl.push_back(mk(0, 1, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd0,   1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 8'd0,   8'd0,   8'd0,   8'd1,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd1,   1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 8'd0,   8'd0,   8'd0,   8'd2,   0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 8'd0,   8'd0,   8'd0,   8'd2,   0, 0, 0));

        foreach (tbl[i]) run_row(tbl[i]);

        // Full-range limit 255, single round: count reaches all-ones, then wraps to 0.
        run_row(mk(0, 1, 0, 1, 0, 8'd255, 8'd1, 8'd0, 8'd2, 0, 0, 0));
        for (int i = 0; i < 256; i++) begin
            run_row(mk(0, 0, 0, 1, 0, 8'd0, 8'd0, 8'(i), 8'd0, i == 255, i == 255, 1));
        end
        run_row(mk(0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd1, 0, 0, 0));

        // Limit 0, free-running for 257 cycles: round_o wraps modulo 256.
        run_row(mk(0, 1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd1, 0, 0, 0));
        for (int i = 0; i < 257; i++) begin
            run_row(mk(0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0, 8'(i), 1, 0, 1));
        end
        run_row(mk(0, 0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 8'd1, 0, 0, 1));
        run_row(mk(0, 0, 0, 1, 0, 8'd0, 8'd0, 8'd0, 8'd1, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_ring_counter.md
PARAM_RING_COUNTER -- requirements
Module: param_ring_counter

Interface
REQ-001 Parameter WIDTH, default 8: count, limit and output width in bits (legal range 2..16).
REQ-002 Parameter RW, default 8: round-count width in bits (legal range 1..16).
REQ-003 clk  in  1  clock; all state SHALL change on its rising edge only.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse that launches a run; honoured only in IDLE.
REQ-006 stop  in  1  abort; honoured only in RUN.
REQ-007 en  in  1  count enable; the counter advances only while this is high.
REQ-008 dir  in  1  direction, captured at start: 0 = up, 1 = down.
REQ-009 i_num_cnt  in  WIDTH  terminal count (limit), captured at start.
REQ-010 i_num_round  in  RW  rounds per run, captured at start; 0 = free-running.
REQ-011 cnt_o  out  WIDTH  current count register.
REQ-012 round_o  out  RW  completed rounds in the current or last run.
REQ-013 wrap_o  out  1  combinational; high in the cycle a wrap occurs.
REQ-014 done_o  out  1  combinational; high in the cycle of the final wrap of a run.
REQ-015 busy_o  out  1  high while the FSM is in RUN.

Function
REQ-016 FSM SHALL have exactly two states, IDLE and RUN; busy_o = (state == RUN).
REQ-017 IDLE & start: on the next edge the block SHALL
  - capture lim <= i_num_cnt, d <= dir, nr <= i_num_round
  - set round_o <= 0
  - set cnt_o <= 0 if dir = 0, else i_num_cnt
  - enter RUN.
REQ-018 IDLE & !start: all registers SHALL hold; en and stop SHALL be ignored.
REQ-019 RUN & start: start SHALL be ignored; captured values SHALL not change mid-run.
REQ-020 Terminal condition term: (d = 0 & cnt_o == lim) or (d = 1 & cnt_o == 0).
REQ-021 wrap_o SHALL equal RUN & en & !stop & term, with zero latency, in the same cycle that the terminal value is on cnt_o.
REQ-022 RUN & en & !stop & !term: cnt_o SHALL become cnt_o + 1 (up) or cnt_o - 1 (down) on the next edge.
REQ-023 On wrap: cnt_o SHALL reload to 0 (up) or lim (down), and round_o SHALL increment modulo 2^RW.
REQ-024 done_o SHALL equal wrap_o & (nr != 0) & (round_o == nr - 1).
REQ-025 On a done_o cycle, the next edge SHALL:
  - perform the REQ-023 reload
  - set round_o <= nr
  - return the FSM to IDLE.
REQ-026 When nr = 0 the block SHALL never assert done_o; round_o wraps modulo 2^RW and RUN continues until stop.
REQ-027 RUN & !en & !stop: all registers SHALL hold; wrap_o and done_o SHALL be 0.
REQ-028 RUN & stop: the next state SHALL be IDLE with cnt_o and round_o frozen.
  - stop has priority over en.
  - wrap_o and done_o SHALL be 0 in that cycle.
REQ-029 lim = 0: term is true in every RUN cycle, so wrap_o = en in every such cycle and cnt_o stays 0; round_o counts enabled cycles.
REQ-030 lim = 2^WIDTH - 1 (up): the count SHALL reach the all-ones value before the wrap; there is no arithmetic overflow path.
REQ-031 All arithmetic SHALL be unsigned at WIDTH and RW bits; carries out SHALL be discarded.

Reset
REQ-032 rst high at an edge SHALL force:
  - state = IDLE
  - cnt_o = 0, round_o = 0, lim = 0, nr = 0, d = 0.
REQ-033 rst SHALL override start, stop and en in the same cycle, including mid-run.
REQ-034 During and after reset, wrap_o = done_o = busy_o = 0 until a new start.

Verification
REQ-035 Up, single round (WIDTH = 8, i_num_cnt = 3, i_num_round = 1, dir = 0, en = 1, start) -> cnt_o 0,1,2,3; wrap_o and done_o high at cnt_o = 3; next cycle cnt_o = 0, round_o = 1, busy_o = 0.
REQ-036 Down, 2 rounds (i_num_cnt = 2, dir = 1) -> cnt_o 2,1,0,2,1,0; wrap_o at both 0s; done_o only at the second; round_o ends at 2.
REQ-037 Gated enable (en toggling 1,0,1,0 with i_num_cnt = 5) -> cnt_o advances only on en = 1 cycles; no wrap_o while en = 0.
REQ-038 Free-running with stop (i_num_round = 0, i_num_cnt = 1) -> wrap_o every second cycle; done_o never asserted; stop asserted in a term cycle -> wrap_o = 0 in that cycle, IDLE next, cnt_o frozen.
REQ-039 Reset mid-run (rst at cnt_o = 4, round_o = 1) -> next cycle cnt_o = 0, round_o = 0, busy_o = 0; a start issued in the reset cycle is ignored.
REQ-040 Boundaries:
  - i_num_cnt = 0 -> wrap_o every enabled cycle, cnt_o stays 0.
  - i_num_cnt = 255, up -> cnt_o reaches 255, then 0.
  - start during RUN -> no effect.
